vga_layer_compositor: RTL and testbench
=======================================

// Module: vga_layer_compositor
// PURPOSE
//  Parametrised N-layer pixel compositor between sprite/tile generators and the VGA pins.
//  - Per pixel: selects the highest-priority layer whose enable is set and whose colour is not transparent.
//  - Applies a frame-latched background colour and layer mask, and blanks outside the active area.
//  - Delays hsync/vsync/bright to stay aligned with the RGB output.
// PARAMETERS
//  N_LAYERS     6       number of input layers; index 0 = highest priority
//  RGB_W        12      pixel width, packed {R,G,B}, 4 bits each
//  TRANSP_KEY   12'hF0F colour treated as transparent on every layer
//  DEFAULT_BG   12'h69C background colour after reset
//  SYNC_POL     0       active level of hsync/vsync (0 = active low)
//  CNT_W        19      width of the overlap counter
// PORTS
//  clk           in   1             system clock, 100 MHz
//  reset         in   1             synchronous, active-high
//  layer_rgb     in   N_LAYERS*RGB_W  layer i occupies bits [i*RGB_W +: RGB_W]
//  layer_en      in   N_LAYERS      layer i pixel present at this hCount/vCount
//  layer_mask    in   N_LAYERS      runtime layer enable; sampled at frame start only
//  bg_rgb        in   RGB_W         background colour; sampled at frame start only
//  bright_in     in   1             active-video flag from display_controller
//  hsync_in      in   1             from display_controller
//  vsync_in      in   1             from display_controller
//  vga_rgb       out  RGB_W         composited pixel
//  hsync_out     out  1             hsync_in delayed 2 cycles
//  vsync_out     out  1             vsync_in delayed 2 cycles
//  bright_out    out  1             bright_in delayed 2 cycles
//  win_layer     out  $clog2(N_LAYERS+1)  winning layer index; N_LAYERS = background
//  overlap_count out  CNT_W         layer-0 overlap pixel count of last frame
//  overlap_valid out  1             1-cycle pulse when overlap_count updates
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset values: vga_rgb=0, bright_out=0, win_layer=N_LAYERS.
//    hsync_out and vsync_out reset to the inactive level (~SYNC_POL).
//    Shadow mask is all ones, shadow bg is DEFAULT_BG.
//    overlap_count=0 and overlap_valid=0.
//  - Latency: 2 cycles, fixed for every input, with no bubbles.
//    S1 registers the inputs and computes hit[i] = layer_en[i] & mask_sh[i] & (rgb_i != TRANSP_KEY).
//    S2 performs priority select and registers the outputs.
//  - Priority select: the lowest index i with hit[i] set wins.
//    No hit -> background shadow colour is output and win_layer = N_LAYERS.
//  - Blanking: if bright is 0 at S2, vga_rgb = 0 and win_layer = N_LAYERS, regardless of hits.
//  - Frame start: the first cycle where vsync_in == SYNC_POL and the previous vsync_in != SYNC_POL.
//    On that cycle mask_sh <= layer_mask and bg_sh <= bg_rgb.
//    The new values take effect from the next cycle.
//    Changes to these inputs mid-frame have no visible effect until the next frame start.
//  - Reset mid-frame: the pipeline is flushed to reset values and the next frame starts clean.
//    Frame-start detection requires one non-active vsync sample after reset.
// CONFIGURATION
//  OVERLAP_COUNT_EN defined:
//    - Accumulator +1 per S2 cycle with bright=1, hit[0]=1 and any hit[1..N-1]=1.
//      This covers player-vs-explosion/enemy detection.
//    - The accumulator saturates at 2^CNT_W-1.
//    - At frame start: overlap_count <= accumulator, overlap_valid=1 for 1 cycle, accumulator <= 0.
//  OVERLAP_COUNT_EN undefined: overlap_count=0 and overlap_valid=0 permanently; no counter logic is built.
// STRUCTURE
//  - Shared package vga_pkg holds:
//    - the rgb_t typedef (12-bit)
//    - DEFAULT_BG and TRANSP_KEY constants
//    - the SYNC_ACTIVE_LOW constant
//  - Sub-module vga_priority_select: combinational hit vector + rgb bus + bg -> rgb, index.
//    It is instantiated in S2.
//  - The top-level file holds the pipeline registers, frame-start detector, shadow registers and optional counter.
// TESTING
//  - Priority: layers 1 and 4 hit with bright=1.
//    -> 2 cycles later vga_rgb = layer1 colour, win_layer = 1.
//  - Transparency: layer 0 = 12'hF0F enabled, layer 2 = 12'h0F0 enabled.
//    -> vga_rgb = 12'h0F0, win_layer = 2.
//  - Background and blanking: no layer enabled -> vga_rgb = 12'h69C.
//    Drop bright_in to 0 -> vga_rgb = 0 and bright_out = 0, both 2 cycles later.
//  - Shadowing: set layer_mask = 6'b111110 and bg_rgb = 12'h123 mid-frame.
//    -> Layer 0 is still shown until the next vsync fall; after it, layer 0 is suppressed and bg = 12'h123.
//  - Overlap (OVERLAP_COUNT_EN): layers 0 and 3 both hit for 37 bright pixels in a frame.
//    -> At the next frame start overlap_count = 37 and overlap_valid is a 1-cycle pulse.
//  - Sync alignment and reset: hsync/vsync/bright edges appear on the outputs exactly 2 cycles later.
//    Assert reset mid-line -> all outputs are at reset values on the next cycle.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA compositing path.
package vga_pkg;
  typedef logic [11:0] rgb_t;

  localparam rgb_t DEFAULT_BG      = 12'h69C;
  localparam rgb_t TRANSP_KEY      = 12'hF0F;
  localparam logic SYNC_ACTIVE_LOW = 1'b0;
endpackage

// File: rtl/vga_priority_select.sv
// Combinational priority pick: the lowest-index hit layer wins, else background.
module vga_priority_select
  import vga_pkg::*;
#(
  parameter int N_LAYERS = 6,
  parameter int RGB_W    = 12,
  parameter int IDX_W    = 3
) (
  input  logic [N_LAYERS-1:0]       hit,
  input  logic [N_LAYERS*RGB_W-1:0] rgb_bus,
  input  logic [RGB_W-1:0]          bg_rgb,
  output logic [RGB_W-1:0]          sel_rgb,
  output logic [IDX_W-1:0]          sel_idx
);

  // Scan from lowest priority upward so the last assignment is the winner.
  always_comb begin
    sel_rgb = bg_rgb;
    sel_idx = IDX_W'(N_LAYERS);
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_rgb = rgb_bus[i*RGB_W +: RGB_W];
        sel_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// N-layer pixel compositor, 2-cycle fixed latency, frame-latched mask/background.
// Optional layer-0 overlap counter built when OVERLAP_COUNT_EN is defined.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int               N_LAYERS   = 6,
  parameter int               RGB_W      = 12,
  parameter logic [RGB_W-1:0] TRANSP_KEY = vga_pkg::TRANSP_KEY,
  parameter logic [RGB_W-1:0] DEFAULT_BG = vga_pkg::DEFAULT_BG,
  parameter logic             SYNC_POL   = SYNC_ACTIVE_LOW,
  parameter int               CNT_W      = 19,
  localparam int              IDX_W      = $clog2(N_LAYERS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [N_LAYERS-1:0]       layer_mask,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic                      bright_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  output logic [RGB_W-1:0]          vga_rgb,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      bright_out,
  output logic [IDX_W-1:0]          win_layer,
  output logic [CNT_W-1:0]          overlap_count,
  output logic                      overlap_valid
);

  logic [N_LAYERS-1:0]       mask_sh_reg;
  logic [RGB_W-1:0]          bg_sh_reg;
  logic                      vs_prev_reg;
  logic [N_LAYERS*RGB_W-1:0] rgb_s1_reg;
  logic [N_LAYERS-1:0]       hit_s1_reg;
  logic                      bright_s1_reg;
  logic                      hsync_s1_reg;
  logic                      vsync_s1_reg;
  logic [N_LAYERS-1:0]       hit_next;
  logic [RGB_W-1:0]          sel_rgb;
  logic [IDX_W-1:0]          sel_idx;
  logic                      frame_start;

  // vs_prev resets to the active level so a frame start needs a fresh inactive sample.
  assign frame_start = (vsync_in == SYNC_POL) && (vs_prev_reg != SYNC_POL);

  generate
    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_hit
      assign hit_next[gi] = layer_en[gi] & mask_sh_reg[gi] &
                            (layer_rgb[gi*RGB_W +: RGB_W] != TRANSP_KEY);
    end
  endgenerate

  vga_priority_select #(
    .N_LAYERS(N_LAYERS),
    .RGB_W   (RGB_W),
    .IDX_W   (IDX_W)
  ) u_select (
    .hit    (hit_s1_reg),
    .rgb_bus(rgb_s1_reg),
    .bg_rgb (bg_sh_reg),
    .sel_rgb(sel_rgb),
    .sel_idx(sel_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_sh_reg   <= '1;
      bg_sh_reg     <= DEFAULT_BG;
      vs_prev_reg   <= SYNC_POL;
      rgb_s1_reg    <= '0;
      hit_s1_reg    <= '0;
      bright_s1_reg <= 1'b0;
      hsync_s1_reg  <= ~SYNC_POL;
      vsync_s1_reg  <= ~SYNC_POL;
      vga_rgb       <= '0;
      win_layer     <= IDX_W'(N_LAYERS);
      bright_out    <= 1'b0;
      hsync_out     <= ~SYNC_POL;
      vsync_out     <= ~SYNC_POL;
    end else begin
      vs_prev_reg <= vsync_in;
      if (frame_start) begin
        mask_sh_reg <= layer_mask;
        bg_sh_reg   <= bg_rgb;
      end
      rgb_s1_reg    <= layer_rgb;
      hit_s1_reg    <= hit_next;
      bright_s1_reg <= bright_in;
      hsync_s1_reg  <= hsync_in;
      vsync_s1_reg  <= vsync_in;
      if (bright_s1_reg) begin
        vga_rgb   <= sel_rgb;
        win_layer <= sel_idx;
      end else begin
        vga_rgb   <= '0;
        win_layer <= IDX_W'(N_LAYERS);
      end
      bright_out <= bright_s1_reg;
      hsync_out  <= hsync_s1_reg;
      vsync_out  <= vsync_s1_reg;
    end
  end

`ifdef OVERLAP_COUNT_EN
  logic [CNT_W-1:0] acc_reg;
  logic             overlap_hit;

  assign overlap_hit = bright_s1_reg & hit_s1_reg[0] & (|hit_s1_reg[N_LAYERS-1:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg       <= '0;
      overlap_count <= '0;
      overlap_valid <= 1'b0;
    end else if (frame_start) begin
      overlap_count <= acc_reg;
      overlap_valid <= 1'b1;
      acc_reg       <= '0;
    end else begin
      overlap_valid <= 1'b0;
      if (overlap_hit && (acc_reg != {CNT_W{1'b1}}))
        acc_reg <= acc_reg + 1'b1;
    end
  end
`else
  assign overlap_count = '0;
  assign overlap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench: randomized raster stimulus against an edge-indexed history model.
module tb_vga_layer_compositor;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] layer_rgb;
  logic [5:0]  layer_en;
  logic [5:0]  layer_mask;
  logic [11:0] bg_rgb;
  logic        bright_in, hsync_in, vsync_in;
  logic [11:0] vga_rgb;
  logic        hsync_out, vsync_out, bright_out;
  logic [2:0]  win_layer;
  logic [18:0] overlap_count;
  logic        overlap_valid;

  int n_checks = 0;
  int n_pass   = 0;

  vga_layer_compositor dut (
    .clk          (clk),
    .reset        (reset),
    .layer_rgb    (layer_rgb),
    .layer_en     (layer_en),
    .layer_mask   (layer_mask),
    .bg_rgb       (bg_rgb),
    .bright_in    (bright_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .vga_rgb      (vga_rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .bright_out   (bright_out),
    .win_layer    (win_layer),
    .overlap_count(overlap_count),
    .overlap_valid(overlap_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Input history indexed by posedge number (edge 1 is the first rising edge).
  logic [71:0] h_rgb  [0:MAXC];
  logic [5:0]  h_en   [0:MAXC];
  logic [5:0]  h_mask [0:MAXC];
  logic [11:0] h_bg   [0:MAXC];
  logic        h_br   [0:MAXC];
  logic        h_hs   [0:MAXC];
  logic        h_vs   [0:MAXC];
  logic        h_rst  [0:MAXC];
  logic [5:0]  m_mask [0:MAXC];
  logic [11:0] m_bg   [0:MAXC];
  int ecount = 0;

  always @(posedge clk) begin
    if (ecount + 1 <= MAXC) begin
      h_rgb[ecount+1]  <= layer_rgb;
      h_en[ecount+1]   <= layer_en;
      h_mask[ecount+1] <= layer_mask;
      h_bg[ecount+1]   <= bg_rgb;
      h_br[ecount+1]   <= bright_in;
      h_hs[ecount+1]   <= hsync_in;
      h_vs[ecount+1]   <= vsync_in;
      h_rst[ecount+1]  <= reset;
    end
    ecount <= ecount + 1;
  end

  // Model state: outputs expected after edge k, computed from the input history.
  int          k, j, win_i;
  logic        fs, prev_act, ov_hit;
  logic [71:0] pix;
  logic [5:0]  hitv, msk;
  logic [11:0] e_rgb;
  logic [2:0]  e_win;
  logic        e_hs, e_vs, e_br, e_val;
  logic [18:0] acc, e_cnt;

  always @(negedge clk) begin
    k = ecount;
    if (k >= 1 && k < MAXC) begin
      if (h_rst[k]) begin
        m_mask[k] = 6'b111111;
        m_bg[k]   = 12'h69C;
        e_rgb = 12'h000; e_win = 3'd6; e_hs = 1'b1; e_vs = 1'b1; e_br = 1'b0;
        acc = '0; e_cnt = '0; e_val = 1'b0;
      end else begin
        prev_act  = (k == 1) || h_rst[k-1] || (h_vs[k-1] == 1'b0);
        fs        = (h_vs[k] == 1'b0) && !prev_act;
        m_mask[k] = fs ? h_mask[k] : m_mask[k-1];
        m_bg[k]   = fs ? h_bg[k]   : m_bg[k-1];
        ov_hit    = 1'b0;
        if (k < 2 || h_rst[k-1]) begin
          e_rgb = 12'h000; e_win = 3'd6; e_hs = 1'b1; e_vs = 1'b1; e_br = 1'b0;
        end else begin
          j   = k - 1;
          pix = h_rgb[j];
          msk = m_mask[k-2];
          for (int i = 0; i < 6; i++)
            hitv[i] = h_en[j][i] && msk[i] && (pix[i*12 +: 12] != 12'hF0F);
          win_i = 6;
          for (int i = 5; i >= 0; i--) if (hitv[i]) win_i = i;
          if (!h_br[j]) begin
            e_rgb = 12'h000; e_win = 3'd6;
          end else if (win_i == 6) begin
            e_rgb = m_bg[k-1]; e_win = 3'd6;
          end else begin
            e_rgb = pix[win_i*12 +: 12]; e_win = 3'(win_i);
          end
          e_hs = h_hs[j]; e_vs = h_vs[j]; e_br = h_br[j];
          ov_hit = h_br[j] && hitv[0] && (hitv[5:1] != 5'd0);
        end
`ifdef OVERLAP_COUNT_EN
        if (fs) begin
          e_cnt = acc; e_val = 1'b1; acc = '0;
        end else begin
          e_val = 1'b0;
          if (ov_hit && acc != 19'h7FFFF) acc = acc + 19'd1;
        end
`else
        e_cnt = '0; e_val = 1'b0;
`endif
      end
      chk("model_rgb",    32'(vga_rgb),       32'(e_rgb));
      chk("model_win",    32'(win_layer),     32'(e_win));
      chk("model_hsync",  32'(hsync_out),     32'(e_hs));
      chk("model_vsync",  32'(vsync_out),     32'(e_vs));
      chk("model_bright", 32'(bright_out),    32'(e_br));
      chk("model_ocount", 32'(overlap_count), 32'(e_cnt));
      chk("model_ovalid", 32'(overlap_valid), 32'(e_val));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [71:0] put(input logic [71:0] bus, input int idx, input logic [11:0] c);
    logic [71:0] b;
    b = bus;
    b[idx*12 +: 12] = c;
    return b;
  endfunction

  initial begin
    reset = 1'b1; layer_rgb = '0; layer_en = '0; layer_mask = 6'b111111;
    bg_rgb = 12'h69C; bright_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    step(3);
    chk("reset_rgb", 32'(vga_rgb), 32'h0);
    chk("reset_win", 32'(win_layer), 32'd6);
    chk("reset_hsync", 32'(hsync_out), 32'd1);
    chk("reset_ovalid", 32'(overlap_valid), 32'd0);
    reset = 1'b0;
    step(2);

    // Priority: layers 1 and 4 hit.
    layer_rgb = put('0, 1, 12'hA51); layer_rgb = put(layer_rgb, 4, 12'h3C7);
    layer_en = 6'b010010; bright_in = 1'b1;
    step(2);
    chk("prio_rgb", 32'(vga_rgb), 32'hA51);
    chk("prio_win", 32'(win_layer), 32'd1);
    $display("txn priority: rgb=%h win=%0d", vga_rgb, win_layer);

    // Transparency key on layer 0 falls through to layer 2.
    layer_rgb = put('0, 0, 12'hF0F); layer_rgb = put(layer_rgb, 2, 12'h0F0);
    layer_en = 6'b000101;
    step(2);
    chk("transp_rgb", 32'(vga_rgb), 32'h0F0);
    chk("transp_win", 32'(win_layer), 32'd2);
    $display("txn transparency: rgb=%h win=%0d", vga_rgb, win_layer);

    // Background, then blanking.
    layer_en = 6'b000000;
    step(2);
    chk("bg_rgb", 32'(vga_rgb), 32'h69C);
    chk("bg_win", 32'(win_layer), 32'd6);
    bright_in = 1'b0;
    step(1);
    chk("blank_early_bright", 32'(bright_out), 32'd1);
    step(1);
    chk("blank_rgb", 32'(vga_rgb), 32'h0);
    chk("blank_bright", 32'(bright_out), 32'd0);
    $display("txn blanking: rgb=%h bright_out=%0d", vga_rgb, bright_out);

    // Sync edge shows up exactly two cycles later.
    bright_in = 1'b1; hsync_in = 1'b0;
    step(1);
    chk("hsync_d1", 32'(hsync_out), 32'd1);
    step(1);
    chk("hsync_d2", 32'(hsync_out), 32'd0);
    hsync_in = 1'b1;
    $display("txn sync: hsync_out=%0d", hsync_out);

    // Shadowing: mask/bg changes are invisible until frame start.
    layer_rgb = put('0, 0, 12'hABC); layer_en = 6'b000001;
    layer_mask = 6'b111110; bg_rgb = 12'h123;
    step(2);
    chk("shadow_pre_rgb", 32'(vga_rgb), 32'hABC);
    chk("shadow_pre_win", 32'(win_layer), 32'd0);
    vsync_in = 1'b0;
    step(1);
    vsync_in = 1'b1;
    step(2);
    chk("shadow_post_rgb", 32'(vga_rgb), 32'h123);
    chk("shadow_post_win", 32'(win_layer), 32'd6);
    $display("txn shadow: rgb=%h win=%0d", vga_rgb, win_layer);

    // Overlap: restore mask, then 37 pixels with layers 0 and 3 hit.
    layer_mask = 6'b111111; bg_rgb = 12'h69C;
    vsync_in = 1'b0;
    step(1);
    vsync_in = 1'b1;
    layer_rgb = put('0, 0, 12'h111); layer_rgb = put(layer_rgb, 3, 12'h333);
    layer_en = 6'b001001;
    step(37);
    layer_en = 6'b000000;
    step(3);
    vsync_in = 1'b0;
    step(1);
`ifdef OVERLAP_COUNT_EN
    chk("overlap_count", 32'(overlap_count), 32'd37);
    chk("overlap_pulse", 32'(overlap_valid), 32'd1);
`else
    chk("overlap_count_off", 32'(overlap_count), 32'd0);
    chk("overlap_pulse_off", 32'(overlap_valid), 32'd0);
`endif
    vsync_in = 1'b1;
    step(1);
    chk("overlap_pulse_end", 32'(overlap_valid), 32'd0);
    $display("txn overlap: count=%0d", overlap_count);

    // Reset mid-line.
    layer_en = 6'b000001; hsync_in = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    chk("rst_mid_rgb", 32'(vga_rgb), 32'h0);
    chk("rst_mid_win", 32'(win_layer), 32'd6);
    chk("rst_mid_hsync", 32'(hsync_out), 32'd1);
    chk("rst_mid_bright", 32'(bright_out), 32'd0);
    reset = 1'b0; hsync_in = 1'b1;
    $display("txn reset_mid_line: rgb=%h win=%0d", vga_rgb, win_layer);

    // Randomized raster: 40x12 frame, bright 30x9, vsync on line 10.
    for (int f = 0; f < 4; f++) begin
      for (int v = 0; v < 12; v++) begin
        for (int h = 0; h < 40; h++) begin
          bright_in = (h < 30) && (v < 9);
          hsync_in  = !((h >= 32) && (h < 36));
          vsync_in  = (v != 10);
          for (int i = 0; i < 6; i++)
            layer_rgb = put(layer_rgb, i, ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom));
          layer_en = 6'($urandom) & 6'($urandom);
          if ($urandom_range(0, 3) == 0) layer_en[0] = 1'b1;
          if ($urandom_range(0, 60) == 0) begin
            layer_mask = 6'($urandom) | 6'b000001;
            bg_rgb     = 12'($urandom);
          end
          reset = (f == 2) && (v == 4) && (h >= 10) && (h < 12);
          step(1);
        end
      end
      $display("txn frame %0d done", f);
    end
    reset = 1'b0;
    step(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
